// File: rtl/restoring_div8by4_pkg.sv
// Shared constants and FSM encoding for the 8-by-4 restoring divider.
// DW/SW are the dividend/divisor widths; CW sizes the iteration counter.
package restoring_div8by4_pkg;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and restore on underflow.
module div_step #(
    parameter int SW = 4
) (
    input  logic [SW:0]   prem,
    input  logic          bit_in,
    input  logic [SW-1:0] divisor,
    output logic [SW:0]   prem_nxt,
    output logic          q_bit
);

    logic [SW+1:0] shifted;
    logic [SW+1:0] trial;

    // Shift, trial-subtract, and keep the difference only when it did not go negative.
    always_comb begin
        shifted  = {prem, bit_in};
        trial    = shifted - (SW + 2)'(divisor);
        q_bit    = (shifted >= (SW + 2)'(divisor));
        prem_nxt = q_bit ? (SW + 1)'(trial) : (SW + 1)'(shifted);
    end

endmodule

// File: rtl/restoring_div8by4.sv
// Sequential unsigned restoring divider, 8-bit dividend by 4-bit divisor,
// one quotient bit per clock. Optional macro DIV_QOVF_EN adds the q_ovf
// output, flagging quotients that do not fit in SW bits.
module restoring_div8by4
    import restoring_div8by4_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder,
    output logic          dbz
`ifdef DIV_QOVF_EN
    ,
    output logic          q_ovf
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [SW:0]   prem;
    logic [SW:0]   prem_nxt;
    logic [DW-1:0] dvd_sh;
    logic [SW-1:0] dvs;
    logic          q_bit;
    logic          last;
    logic [DW-1:0] q_final;

    // The dividend register doubles as the quotient shift register: each
    // iteration consumes its MSB and shifts the new quotient bit into its LSB.
    div_step #(.SW(SW)) u_step (
        .prem     (prem),
        .bit_in   (dvd_sh[DW-1]),
        .divisor  (dvs),
        .prem_nxt (prem_nxt),
        .q_bit    (q_bit)
    );

    assign last    = (cnt == CW'(DW - 1));
    assign q_final = {dvd_sh[DW-2:0], q_bit};
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state is written with <= so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> RUN (or straight to DONE on zero divisor) -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN:  if (last)  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register is reset so outputs read 0 right after rst_n falls.
        if (!rst_n) begin
            cnt       <= '0;
            prem      <= '0;
            dvd_sh    <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
`ifdef DIV_QOVF_EN
            q_ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_sh <= dividend;
                        dvs    <= divisor;
                        prem   <= '0;
                        cnt    <= '0;
                        dbz    <= (divisor == '0);
`ifdef DIV_QOVF_EN
                        q_ovf  <= 1'b0;
`endif
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                        end
                    end
                end
                S_RUN: begin
                    prem   <= prem_nxt;
                    dvd_sh <= q_final;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        quotient  <= q_final;
                        remainder <= prem_nxt[SW-1:0];
`ifdef DIV_QOVF_EN
                        q_ovf     <= |q_final[DW-1:SW];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
